// File: rtl/game_pkg.sv
// Shared game definitions: state encoding and score limits, imported by the
// score tracker and the game-state FSM so the encodings stay in one place.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2,
        WIN  = 2'd3
    } game_state_t;

    localparam int SCORE_W_DEF   = 7;
    localparam int MAX_SCORE_DEF = 99;

endpackage

// File: rtl/score_tracker_if.sv
// Bundle between the score tracker, the collision logic and the game-state FSM.
interface score_tracker_if
    import game_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
);
    game_state_t        game_state;
    logic               apple_eaten;
    logic [SCORE_W-1:0] score;
    logic [3:0]         bcd_tens;
    logic [3:0]         bcd_ones;
    logic [SCORE_W-1:0] high_score;
    logic               new_high;
    logic               win;

    // Game side: drives state and apple events, consumes the score.
    modport master (
        output game_state, apple_eaten,
        input  score, bcd_tens, bcd_ones, high_score, new_high, win
    );

    // Tracker side.
    modport slave (
        input  game_state, apple_eaten,
        output score, bcd_tens, bcd_ones, high_score, new_high, win
    );
endinterface

// File: rtl/edge_detect.sv
// Rising-edge pulse generator: one-cycle pulse on the first cycle a level is high.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/score_tracker.sv
// Apple-event score counter with BCD mirror, saturating win detection and a
// session high score captured when a run ends.
module score_tracker
    import game_pkg::*;
#(
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int MAX_SCORE = MAX_SCORE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    score_tracker_if.slave  bus
);
    localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

    game_state_t        r_state_q;
    logic [SCORE_W-1:0] r_score;
    logic [3:0]         r_bcd_tens;
    logic [3:0]         r_bcd_ones;
    logic [SCORE_W-1:0] r_high_score;
    logic               r_new_high;
    logic               r_win;

    logic w_hit;
    logic w_run;
    logic w_start;
    logic w_exit;
    logic w_inc;

    edge_detect u_apple_edge (
        .clk    (clk),
        .rst    (reset),
        .i_d    (bus.apple_eaten),
        .o_rise (w_hit)
    );

    assign w_run   = (bus.game_state == RUN);
    assign w_start = w_run & (r_state_q != RUN);
    assign w_exit  = (r_state_q == RUN) & ~w_run;
    // Run-entry clear takes priority: a hit on the entry edge is dropped.
    assign w_inc   = w_run & ~w_start & w_hit & (r_score < MAX_S);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q    <= IDLE;
            r_score      <= '0;
            r_bcd_tens   <= 4'd0;
            r_bcd_ones   <= 4'd0;
            r_high_score <= '0;
            r_new_high   <= 1'b0;
            r_win        <= 1'b0;
        end else begin
            r_state_q <= bus.game_state;

            if (w_start) begin
                r_score    <= '0;
                r_bcd_tens <= 4'd0;
                r_bcd_ones <= 4'd0;
                r_win      <= 1'b0;
                r_new_high <= 1'b0;
            end else if (w_inc) begin
                r_score <= r_score + 1'b1;
                if (r_bcd_ones == 4'd9) begin
                    r_bcd_ones <= 4'd0;
                    r_bcd_tens <= r_bcd_tens + 4'd1;
                end else begin
                    r_bcd_ones <= r_bcd_ones + 4'd1;
                end
                if ((r_score + 1'b1) == MAX_S) begin
                    r_win <= 1'b1;
                end
            end

            // Exit and entry are mutually exclusive, so this never fights the clear.
            if (w_exit && (r_score > r_high_score)) begin
                r_high_score <= r_score;
                r_new_high   <= 1'b1;
            end
        end
    end

    assign bus.score      = r_score;
    assign bus.bcd_tens   = r_bcd_tens;
    assign bus.bcd_ones   = r_bcd_ones;
    assign bus.high_score = r_high_score;
    assign bus.new_high   = r_new_high;
    assign bus.win        = r_win;
endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: driver pushes model predictions per clock,
// monitor pops and compares them one time unit after each rising edge.
module tb_score_tracker;
    import game_pkg::*;

    localparam int SW  = 7;
    localparam int MAX = 99;

    typedef struct {
        int score;
        int tens;
        int ones;
        int high;
        int nh;
        int win;
    } exp_t;

    logic clk;
    logic reset;
    score_tracker_if #(.SCORE_W(SW)) bus ();

    score_tracker #(.SCORE_W(SW), .MAX_SCORE(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state (plain integers)
    int          m_score = 0;
    int          m_high  = 0;
    int          m_nh    = 0;
    int          m_win   = 0;
    bit          m_prev_apple = 0;
    game_state_t m_prev_state = IDLE;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.score = m_score;
        e.tens  = m_score / 10;
        e.ones  = m_score % 10;
        e.high  = m_high;
        e.nh    = m_nh;
        e.win   = m_win;
        return e;
    endfunction

    // Predict the state after one clock edge with the given inputs present.
    function automatic void model(input game_state_t gs, input bit ap, input bit rst);
        bit new_apple;
        bit entering;
        bit leaving;
        if (rst) begin
            m_score = 0; m_high = 0; m_nh = 0; m_win = 0;
            m_prev_apple = 0; m_prev_state = IDLE;
            return;
        end
        new_apple = ap && !m_prev_apple;
        entering  = (gs == RUN) && (m_prev_state != RUN);
        leaving   = (m_prev_state == RUN) && (gs != RUN);
        if (entering) begin
            m_score = 0; m_win = 0; m_nh = 0;
        end else if (gs == RUN && new_apple && m_score < MAX) begin
            m_score = m_score + 1;
            if (m_score == MAX) m_win = 1;
        end
        if (leaving && m_score > m_high) begin
            m_high = m_score;
            m_nh   = 1;
        end
        m_prev_apple = ap;
        m_prev_state = gs;
    endfunction

    task automatic check_now(input string tag, input exp_t e);
        chk({tag, "_score"}, int'(bus.score),      e.score);
        chk({tag, "_tens"},  int'(bus.bcd_tens),   e.tens);
        chk({tag, "_ones"},  int'(bus.bcd_ones),   e.ones);
        chk({tag, "_high"},  int'(bus.high_score), e.high);
        chk({tag, "_newhi"}, int'(bus.new_high),   e.nh);
        chk({tag, "_win"},   int'(bus.win),        e.win);
    endtask

    task automatic step(input game_state_t gs, input bit ap, input bit rst);
        @(posedge clk);
        #2;
        reset           = rst;
        bus.game_state  = gs;
        bus.apple_eaten = ap;
        model(gs, ap, rst);
        q.push_back(snapshot());
    endtask

    task automatic pulses(input game_state_t gs, input int n);
        for (int i = 0; i < n; i++) begin
            step(gs, 1'b1, 1'b0);
            step(gs, 1'b0, 1'b0);
        end
    endtask

    // Reset asserted between edges must clear outputs without a clock.
    task automatic async_reset_check();
        exp_t z;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        z = '{0, 0, 0, 0, 0, 0};
        check_now("async_rst", z);
        model(bus.game_state, bus.apple_eaten, 1'b1);
        q.push_back(snapshot());
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_now("cyc", e);
            end
        end
    end

    // Driver
    initial begin
        exp_t z;
        game_state_t gs;
        bit ap;
        bit rst;
        reset           = 1'b1;
        bus.game_state  = IDLE;
        bus.apple_eaten = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        z = '{0, 0, 0, 0, 0, 0};
        check_now("reset", z);

        // Apples while idle are ignored
        step(IDLE, 1'b0, 1'b0);
        pulses(IDLE, 3);
        // Run to 5, then reset asynchronously mid-run
        step(RUN, 1'b0, 1'b0);
        pulses(RUN, 5);
        async_reset_check();
        step(IDLE, 1'b0, 1'b0);
        step(IDLE, 1'b0, 1'b0);

        // Held level counts once; separate pulse counts again
        step(RUN, 1'b0, 1'b0);
        repeat (4) step(RUN, 1'b1, 1'b0);
        step(RUN, 1'b0, 1'b0);
        step(RUN, 1'b1, 1'b0);
        step(RUN, 1'b0, 1'b0);

        // Through 9->10 carry up to saturation at MAX, then WIN
        pulses(RUN, 110);
        step(WIN, 1'b0, 1'b0);
        pulses(WIN, 2);

        // High score tracking across two runs (fresh session)
        step(IDLE, 1'b0, 1'b1);
        step(IDLE, 1'b0, 1'b0);
        step(RUN, 1'b0, 1'b0);
        pulses(RUN, 12);
        step(OVER, 1'b0, 1'b0);
        step(IDLE, 1'b0, 1'b0);
        step(RUN, 1'b0, 1'b0);
        pulses(RUN, 7);
        step(OVER, 1'b0, 1'b0);
        pulses(OVER, 3);

        // Hit on the run-entry edge is dropped by the clear
        step(RUN, 1'b0, 1'b0);
        pulses(RUN, 40);
        step(OVER, 1'b0, 1'b0);
        step(RUN, 1'b1, 1'b0);
        step(RUN, 1'b0, 1'b0);
        step(RUN, 1'b1, 1'b0);
        step(RUN, 1'b0, 1'b0);

        // Randomized traffic, biased toward RUN, with rare resets
        for (int i = 0; i < 2000; i++) begin
            gs  = ($urandom_range(0, 9) < 7) ? RUN : game_state_t'($urandom_range(0, 3));
            ap  = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step(gs, ap, rst);
        end

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
